cyclic_bram_sched: RTL

CYCLIC_BRAM_SCHED -- requirements
Module: cyclic_bram_sched

---
 rtl/cgra_ctrl_pkg.sv | 17 +
 rtl/n_delay_en.sv | 40 ++++
 rtl/cyclic_bram_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cgra_ctrl_pkg.sv
// Shared control definitions for the cyclic BRAM scheduler: FSM encoding and
// the layout of the read-latency pipeline word.
package cgra_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READ  = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_t;

  // Pipeline word carries {valid, last} alongside each BRAM read.
  localparam int PIPE_W     = 2;
  localparam int PIPE_VALID = 1;
  localparam int PIPE_LAST  = 0;

endpackage

// File: rtl/n_delay_en.sv
// N-stage enabled delay line with asynchronous clear; reports whether any
// stage still holds a word flagged valid.
module n_delay_en #(
  parameter int N    = 3,
  parameter int W    = 2,
  parameter int VBIT = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         occupied
);

  logic [N-1:0][W-1:0] stage_r;

  // Shift one stage per enabled cycle; a stall freezes every stage in place.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stage_r <= '0;
    end else if (en) begin
      stage_r[0] <= d;
      for (int i = 1; i < N; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Occupancy across all stages, used to decide when the flush is complete.
  always_comb begin
    occupied = 1'b0;
    for (int i = 0; i < N; i++) begin
      occupied = occupied | stage_r[i][VBIT];
    end
  end

  assign q = stage_r[N-1];

endmodule

// File: rtl/cyclic_bram_sched.sv
// Sequences one fill pass of BRAM writes followed by repeated wrapped read
// sweeps, tracking read data through the BRAM latency under a global stall.
module cyclic_bram_sched
  import cgra_ctrl_pkg::*;
#(
  parameter int R_DEPTH    = 8,
  parameter int W_DEPTH    = 8,
  parameter int LATENCY    = 3,
  parameter int PASS_WIDTH = 8,
  localparam int R_AW = $clog2(R_DEPTH),
  localparam int W_AW = $clog2(W_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [W_AW-1:0]       cfg_w_max,
  input  logic [R_AW-1:0]       cfg_r_min,
  input  logic [R_AW-1:0]       cfg_r_max,
  input  logic [PASS_WIDTH-1:0] cfg_passes,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  bram_clken,
  output logic                  w_en,
  output logic                  w_last_out,
  output logic                  r_en,
  output logic                  r_last_out,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam logic [W_AW-1:0]       W_ONE = {{(W_AW-1){1'b0}}, 1'b1};
  localparam logic [R_AW-1:0]       R_ONE = {{(R_AW-1){1'b0}}, 1'b1};
  localparam logic [PASS_WIDTH-1:0] P_ONE = {{(PASS_WIDTH-1){1'b0}}, 1'b1};

  sched_state_t          state_r;
  logic [W_AW-1:0]       w_max_r, w_cnt_r;
  logic [R_AW-1:0]       r_min_r, r_max_r, r_addr_r;
  logic [PASS_WIDTH-1:0] passes_r, pass_r;
  logic                  cfg_ready_r, busy_r, done_r, cfg_err_r;
  logic                  clken_s, w_en_s, w_last_s, r_en_s, r_last_s, final_s;
  logic                  pipe_busy_s;
  logic [PIPE_W-1:0]     pipe_in_s, pipe_out_s;

  // Stall and handshake decode from the current state and counters.
  always_comb begin
    clken_s   = ~(pipe_out_s[PIPE_VALID] & ~m_ready);
    w_en_s    = (state_r == ST_FILL) & s_valid & clken_s;
    w_last_s  = w_en_s & (w_cnt_r == w_max_r);
    r_en_s    = (state_r == ST_READ) & clken_s;
    r_last_s  = r_en_s & (r_addr_r == r_max_r);
    final_s   = r_last_s & (pass_r == passes_r - P_ONE);
    pipe_in_s = {r_en_s, final_s};
  end

  n_delay_en #(
    .N    (LATENCY),
    .W    (PIPE_W),
    .VBIT (PIPE_VALID)
  ) u_lat_pipe (
    .clk      (clk),
    .clr      (reset),
    .en       (clken_s),
    .d        (pipe_in_s),
    .q        (pipe_out_s),
    .occupied (pipe_busy_s)
  );

  // Scheduler FSM with its counters, captured configuration and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      w_max_r     <= '0;
      w_cnt_r     <= '0;
      r_min_r     <= '0;
      r_max_r     <= '0;
      r_addr_r    <= '0;
      passes_r    <= '0;
      pass_r      <= '0;
      cfg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (cfg_r_min > cfg_r_max) begin
              cfg_err_r <= 1'b1;
            end else begin
              w_max_r     <= cfg_w_max;
              r_min_r     <= cfg_r_min;
              r_max_r     <= cfg_r_max;
              passes_r    <= cfg_passes;
              w_cnt_r     <= '0;
              pass_r      <= '0;
              r_addr_r    <= cfg_r_min;
              state_r     <= ST_FILL;
              cfg_ready_r <= 1'b0;
              busy_r      <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (w_en_s) begin
            w_cnt_r <= w_cnt_r + W_ONE;
            if (w_last_s) begin
              state_r <= (passes_r == '0) ? ST_FLUSH : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_en_s) begin
            if (r_last_s) begin
              r_addr_r <= r_min_r;
              pass_r   <= pass_r + P_ONE;
            end else begin
              r_addr_r <= r_addr_r + R_ONE;
            end
            if (final_s) begin
              state_r <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Finish as soon as the last word leaves, not a cycle after it drains.
          if (~pipe_busy_s | (pipe_out_s[PIPE_VALID] & m_ready & pipe_out_s[PIPE_LAST])) begin
            state_r     <= ST_IDLE;
            done_r      <= 1'b1;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cfg_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = cfg_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign cfg_err    = cfg_err_r;
  assign bram_clken = clken_s;
  assign s_ready    = (state_r == ST_FILL) & clken_s;
  assign w_en       = w_en_s;
  assign w_last_out = w_last_s;
  assign r_en       = r_en_s;
  assign r_last_out = r_last_s;
  assign m_valid    = pipe_out_s[PIPE_VALID];
  assign m_last     = pipe_out_s[PIPE_LAST];

endmodule
